// File: rtl/music_box_pkg.sv
// Shared definitions for the music box sequencer: ROM word layout, FSM encoding
// and the rest-note decoder used by the sequencer.
package music_box_pkg;

    localparam int         NUM_NOTES_DEF = 36;
    localparam logic [5:0] NOTE_REST     = 6'd63;

    localparam int END_BIT = 15;
    localparam int IDX_MSB = 14;
    localparam int IDX_LSB = 9;
    localparam int DUR_MSB = 8;
    localparam int DUR_LSB = 0;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;
    localparam int DUR_W   = DUR_MSB - DUR_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_e;

    // Index 63 and anything past the last wired note line play as silence.
    function automatic logic is_rest(input logic [IDX_W-1:0] idx, input int num_notes);
        return (idx == NOTE_REST) || (int'(idx) >= num_notes);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into a one-cycle duration tick every TICK_DIV cycles;
// a synchronous clear holds the count at zero so each note starts on a fresh period.
module tick_prescaler #(
    parameter int TICK_DIV = 2500000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int             CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clr || cnt_q == LAST) cnt_d = '0;
        else                      cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/music_box_sequencer.sv
// Song sequencer: walks a synchronous song ROM and drives one note-bank line at a
// time for each event's duration, with an optional silent gap and end-of-song loop.
module music_box_sequencer
    import music_box_pkg::*;
#(
    parameter int NUM_NOTES = NUM_NOTES_DEF,
    parameter int ADDR_W    = 8,
    parameter int TICK_DIV  = 2500000,
    parameter int GAP_TICKS = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [15:0]          rom_data,
    output logic [NUM_NOTES-1:0] note_on,
    output logic                 busy,
    output logic                 song_done
);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [NUM_NOTES-1:0]  note_q, note_d;
    logic [DUR_W-1:0]      remain_q, remain_d;
    logic                  sounded_q, sounded_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tick, tick_clr;

    logic                  rom_end;
    logic [IDX_W-1:0]      rom_idx;
    logic [DUR_W-1:0]      rom_dur;

    assign rom_end = rom_data[END_BIT];
    assign rom_idx = rom_data[IDX_MSB:IDX_LSB];
    assign rom_dur = rom_data[DUR_MSB:DUR_LSB];

    // Prescaler only runs while timing a note or gap, so PLAY always starts at count 0.
    assign tick_clr = !(state_q == ST_PLAY || state_q == ST_GAP);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        note_d    = note_q;
        remain_d  = remain_q;
        sounded_d = sounded_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                note_d = '0;
                if (start) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (rom_end) begin
                    addr_d = '0;
                    if (loop_en) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else if (rom_dur == '0) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                end else begin
                    state_d   = ST_PLAY;
                    remain_d  = rom_dur;
                    sounded_d = !is_rest(rom_idx, NUM_NOTES);
                    note_d    = is_rest(rom_idx, NUM_NOTES) ? '0 : (NUM_NOTES'(1) << rom_idx);
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (remain_q == DUR_W'(1)) begin
                        note_d = '0;
                        addr_d = addr_q + ADDR_W'(1);
                        if (GAP_TICKS > 0 && sounded_q) begin
                            state_d  = ST_GAP;
                            remain_d = DUR_W'(GAP_TICKS);
                        end else begin
                            state_d  = ST_FETCH;
                            remain_d = '0;
                        end
                    end else begin
                        remain_d = remain_q - DUR_W'(1);
                    end
                end
            end
            ST_GAP: begin
                note_d = '0;
                if (tick) begin
                    if (remain_q == DUR_W'(1)) begin
                        state_d  = ST_FETCH;
                        remain_d = '0;
                    end else begin
                        remain_d = remain_q - DUR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (stop) begin
            state_d   = ST_IDLE;
            addr_d    = '0;
            note_d    = '0;
            remain_d  = '0;
            sounded_d = 1'b0;
            done_d    = 1'b0;
        end

        busy_d = !(state_d == ST_IDLE || state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            note_q    <= '0;
            remain_q  <= '0;
            sounded_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            note_q    <= note_d;
            remain_q  <= remain_d;
            sounded_q <= sounded_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rom_addr  = addr_q;
    assign note_on   = note_q;
    assign busy      = busy_q;
    assign song_done = done_q;

endmodule

// File: tb/tb_music_box_sequencer.sv
// Scoreboard bench: each song pushes its expected note segments and song_done
// pulses; a negedge monitor measures what the sequencer actually plays.
module tb_music_box_sequencer;

    localparam int NN = 36;
    localparam int AW = 4;
    localparam int TD = 4;
    localparam int GT = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [NN-1:0] note_on;
    logic          busy;
    logic          song_done;

    logic [15:0]   rom [1 << AW];
    int            cyc = 0;
    int            t_start = 0;
    int            nvec = 0;
    int            nmis = 0;

    typedef struct {
        bit            is_done;
        logic [NN-1:0] note;
        int            len;
        int            dly;
    } ev_t;
    ev_t sb[$];

    music_box_sequencer #(
        .NUM_NOTES (NN),
        .ADDR_W    (AW),
        .TICK_DIV  (TD),
        .GAP_TICKS (GT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note_on   (note_on),
        .busy      (busy),
        .song_done (song_done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) rom_data <= rom[rom_addr];

    function automatic logic [15:0] ev(input int idx, input int dur);
        logic [15:0] w;
        w = 16'h0000;
        w[14:9] = 6'(idx);
        w[8:0]  = 9'(dur);
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_note(input logic [NN-1:0] note, input int len, input int dly);
        ev_t e;
        e.is_done = 1'b0; e.note = note; e.len = len; e.dly = dly;
        sb.push_back(e);
    endtask

    task automatic exp_done(input int dly);
        ev_t e;
        e.is_done = 1'b1; e.note = '0; e.len = 0; e.dly = dly;
        sb.push_back(e);
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic go();
        start = 1'b1;
        t_start = cyc;
        tick_to(cyc + 1);
        start = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < (1 << AW); i++) rom[i] = 16'h0000;
    endtask

    // Monitor: compares each observed note segment / song_done pulse with the queue head.
    task automatic pop_cmp(input bit is_done, input logic [NN-1:0] note, input int len, input int dly);
        ev_t e;
        nvec++;
        if (sb.size() == 0) begin
            nmis++;
            $display("FAIL unexpected_event: got done=%0d note=%0h len=%0d dly=%0d, none expected",
                     is_done, note, len, dly);
        end else begin
            e = sb.pop_front();
            if (e.is_done != is_done || e.note !== note || e.len != len || e.dly != dly) begin
                nmis++;
                $display("FAIL event: got done=%0d note=%0h len=%0d dly=%0d expected done=%0d note=%0h len=%0d dly=%0d",
                         is_done, note, len, dly, e.is_done, e.note, e.len, e.dly);
            end
        end
    endtask

    logic [NN-1:0] cur = '0;
    int            seg_len = 0;
    int            seg_dly = 0;

    always @(negedge clock) begin
        if (song_done === 1'b1) pop_cmp(1'b1, '0, 0, cyc - t_start);
        if (note_on !== cur) begin
            if (cur != '0) pop_cmp(1'b0, cur, seg_len, seg_dly);
            cur     = note_on;
            seg_len = 1;
            seg_dly = cyc - t_start;
        end else if (cur != '0) begin
            seg_len++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_rom();
        tick_to(2);
        chk("reset_note_on", 64'(note_on), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_rom_addr", 64'(rom_addr), 64'h0);
        chk("reset_song_done", 64'(song_done), 64'h0);
        reset = 1'b1;
        tick_to(cyc + 2);

        // 1: single note, gap, then song_done
        clear_rom(); rom[0] = ev(2, 3); rom[1] = 16'h8000;
        exp_note(36'h4, 12, 3); exp_done(21);
        go();
        tick_to(t_start + 3);
        chk("t1_busy_playing", 64'(busy), 64'h1);
        tick_to(t_start + 22);
        chk("t1_busy_done", 64'(busy), 64'h0);
        tick_to(t_start + 26);

        // 2: rest has no trailing gap
        clear_rom(); rom[0] = ev(63, 2); rom[1] = ev(0, 1); rom[2] = 16'h8000;
        exp_note(36'h1, 4, 13); exp_done(23);
        go();
        tick_to(t_start + 8);
        chk("t2_rest_silent", 64'(note_on), 64'h0);
        tick_to(t_start + 26);

        // 3: zero duration skipped, out-of-range index silent
        clear_rom(); rom[0] = ev(5, 0); rom[1] = ev(40, 1); rom[2] = ev(1, 1); rom[3] = 16'h8000;
        exp_note(36'h2, 4, 11); exp_done(21);
        go();
        tick_to(t_start + 24);

        // 4: looping, then stop during a gap
        clear_rom(); rom[0] = ev(3, 1); rom[1] = 16'h8000;
        loop_en = 1'b1;
        exp_note(36'h8, 4, 3); exp_note(36'h8, 4, 15); exp_note(36'h8, 4, 27);
        go();
        tick_to(t_start + 12);
        chk("t4_addr_end", 64'(rom_addr), 64'h1);
        tick_to(t_start + 13);
        chk("t4_addr_wrap", 64'(rom_addr), 64'h0);
        chk("t4_busy_loop", 64'(busy), 64'h1);
        tick_to(t_start + 32);
        stop = 1'b1;
        tick_to(cyc + 1);
        stop = 1'b0;
        loop_en = 1'b0;
        chk("t4_busy_stopped", 64'(busy), 64'h0);
        tick_to(cyc + 4);

        // 5: stop mid-note, then start+stop together
        clear_rom(); rom[0] = ev(7, 3); rom[1] = 16'h8000;
        exp_note(36'h80, 3, 3);
        go();
        tick_to(t_start + 5);
        stop = 1'b1;
        tick_to(t_start + 6);
        stop = 1'b0;
        chk("t5_stop_note", 64'(note_on), 64'h0);
        chk("t5_stop_addr", 64'(rom_addr), 64'h0);
        chk("t5_stop_busy", 64'(busy), 64'h0);
        start = 1'b1; stop = 1'b1;
        tick_to(cyc + 1);
        start = 1'b0; stop = 1'b0;
        chk("t5_startstop_busy", 64'(busy), 64'h0);
        chk("t5_startstop_addr", 64'(rom_addr), 64'h0);
        tick_to(cyc + 6);
        chk("t5_still_silent", 64'(note_on), 64'h0);

        // 6: reset mid-note, then address wrap without END
        clear_rom(); rom[0] = ev(4, 3); rom[1] = 16'h8000;
        exp_note(36'h10, 3, 3);
        go();
        tick_to(t_start + 5);
        reset = 1'b0;
        tick_to(t_start + 6);
        reset = 1'b1;
        chk("t6_rst_note", 64'(note_on), 64'h0);
        chk("t6_rst_busy", 64'(busy), 64'h0);
        chk("t6_rst_addr", 64'(rom_addr), 64'h0);
        chk("t6_rst_done", 64'(song_done), 64'h0);
        tick_to(cyc + 2);
        clear_rom();
        go();
        tick_to(t_start + 31);
        chk("t6_addr_last", 64'(rom_addr), 64'hf);
        tick_to(t_start + 33);
        chk("t6_addr_wrapped", 64'(rom_addr), 64'h0);
        chk("t6_busy_wrapped", 64'(busy), 64'h1);
        stop = 1'b1;
        tick_to(cyc + 1);
        stop = 1'b0;
        tick_to(cyc + 4);

        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
